// File: rtl/mainfsm_gen2.sv
// Multicycle main control FSM with a multi-cycle multiply path.
// Define MAINFSM_LONGMUL_EN to build in the MULWBHI state and LongMul path.
module mainfsm_gen2 #(
  parameter int MUL_CYCLES    = 2,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MulInstr,
  input  logic       LongMul,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       NextPC,
  output logic       RegW,
  output logic       RegWHi,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       MulStart,
  output logic       MulBusy,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] UNKNOWN  = 4'd10;
  localparam logic [3:0] MULEX    = 4'd11;
  localparam logic [3:0] MULWB    = 4'd12;
  localparam logic [3:0] MULWBHI  = 4'd13;

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  logic [3:0] state;
  logic [3:0] state_n;
  logic [3:0] cur;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic       mem_rdy;
  logic       unused_in;

  assign mem_rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

`ifdef MAINFSM_LONGMUL_EN
  assign unused_in = ^Funct[4:1];
`else
  assign unused_in = ^{Funct[4:1], LongMul};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      FETCH: begin
        if (mem_rdy) state_n = DECODE;
      end
      DECODE: begin
        unique case (Op)
          2'b00: begin
            if (MulInstr) begin
              state_n = MULEX;
              cnt_n   = 4'd0;
            end else if (Funct[5]) begin
              state_n = EXECUTEI;
            end else begin
              state_n = EXECUTER;
            end
          end
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          default: state_n = UNKNOWN;
        endcase
      end
      MEMADR: begin
        state_n = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        if (mem_rdy) state_n = MEMWB;
      end
      MEMWR: begin
        if (mem_rdy) state_n = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        state_n = ALUWB;
      end
      MEMWB, ALUWB, BRANCH, UNKNOWN: begin
        state_n = FETCH;
      end
      MULEX: begin
        if (cnt == MUL_LAST) begin
          state_n = MULWB;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      MULWB: begin
`ifdef MAINFSM_LONGMUL_EN
        state_n = LongMul ? MULWBHI : FETCH;
`else
        state_n = FETCH;
`endif
      end
`ifdef MAINFSM_LONGMUL_EN
      MULWBHI: begin
        state_n = FETCH;
      end
`endif
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // Reset forces the FETCH decode so controls are sane before the first edge.
  assign cur   = reset ? FETCH : state;
  assign State = cur;

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    RegWHi    = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    MulStart  = 1'b0;
    MulBusy   = 1'b0;
    Illegal   = 1'b0;
    unique case (cur)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_rdy;
        NextPC    = mem_rdy;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUOp = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      UNKNOWN: begin
        Illegal = 1'b1;
      end
      MULEX: begin
        MulBusy  = 1'b1;
        MulStart = (cnt == 4'd0);
      end
      MULWB: begin
        RegW = 1'b1;
      end
`ifdef MAINFSM_LONGMUL_EN
      MULWBHI: begin
        RegWHi = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mainfsm_gen2.sv
// Randomized instruction-level bench for mainfsm_gen2.
// Expected per-cycle state/control trace is built from instruction class.
module tb_mainfsm_gen2;

  localparam int MC = 3;
`ifdef MAINFSM_LONGMUL_EN
  localparam bit LM_EN = 1'b1;
`else
  localparam bit LM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic       MulInstr = 1'b0;
  logic       LongMul = 1'b0;
  logic       MemReady = 1'b0;

  logic IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, RegWHi, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcB, ResultSrc;
  logic MulStart, MulBusy, Illegal;
  logic [3:0] State;

  logic h_IRWrite, h_AdrSrc, h_ALUSrcA, h_NextPC, h_RegW, h_RegWHi;
  logic h_MemW, h_Branch, h_ALUOp;
  logic [1:0] h_ALUSrcB, h_ResultSrc;
  logic h_MulStart, h_MulBusy, h_Illegal;
  logic [3:0] h_State;

  mainfsm_gen2 #(.MUL_CYCLES(MC), .MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .MulInstr(MulInstr), .LongMul(LongMul), .MemReady(MemReady),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .NextPC(NextPC), .RegW(RegW), .RegWHi(RegWHi), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .MulStart(MulStart), .MulBusy(MulBusy),
    .Illegal(Illegal), .State(State)
  );

  mainfsm_gen2 #(.MUL_CYCLES(2), .MEM_HANDSHAKE(0)) u_nohs (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .MulInstr(MulInstr), .LongMul(LongMul), .MemReady(MemReady),
    .IRWrite(h_IRWrite), .AdrSrc(h_AdrSrc), .ALUSrcA(h_ALUSrcA),
    .NextPC(h_NextPC), .RegW(h_RegW), .RegWHi(h_RegWHi), .MemW(h_MemW),
    .Branch(h_Branch), .ALUOp(h_ALUOp), .ALUSrcB(h_ALUSrcB),
    .ResultSrc(h_ResultSrc), .MulStart(h_MulStart), .MulBusy(h_MulBusy),
    .Illegal(h_Illegal), .State(h_State)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, RegWHi, MemW,
                Branch, ALUOp, ALUSrcB, ResultSrc, MulStart, MulBusy,
                Illegal};

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       first;
  } ent_t;

  ent_t q[$];
  logic [1:0] i_op;
  logic [5:0] i_funct;
  logic       i_mi;
  logic       i_lm;

  function automatic logic [15:0] exp_ctrl(logic [3:0] st, logic mr,
                                           logic first);
    logic irw, adr, asa, npc, rw, rwh, mw, br, aop, ms, mb, il;
    logic [1:0] asb, rs;
    {irw, adr, asa, npc, rw, rwh, mw, br, aop, ms, mb, il} = '0;
    asb = 2'b00;
    rs  = 2'b00;
    case (st)
      4'd0:  begin asa = 1; asb = 2; rs = 2; irw = mr; npc = mr; end
      4'd1:  begin asa = 1; asb = 2; rs = 2; end
      4'd2:  asb = 1;
      4'd3:  adr = 1;
      4'd4:  begin rs = 1; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  aop = 1;
      4'd7:  begin asb = 1; aop = 1; end
      4'd8:  rw = 1;
      4'd9:  begin asb = 1; rs = 2; br = 1; end
      4'd10: il = 1;
      4'd11: begin mb = 1; ms = first; end
      4'd12: rw = 1;
      4'd13: rwh = LM_EN;
      default: ;
    endcase
    return {irw, adr, asa, npc, rw, rwh, mw, br, aop, asb, rs, ms, mb, il};
  endfunction

  task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(logic [3:0] st, logic mr, logic first);
    ent_t e;
    e.st = st;
    e.mr = mr;
    e.first = first;
    q.push_back(e);
  endtask

  // kind: 0 ADD 1 ADDI 2 LDR 3 STR 4 B 5 UND 6 MUL; lm<0 means random
  task automatic build(int kind, int fst, int wst, int lm);
    q.delete();
    i_funct = 6'($urandom);
    i_mi = 1'b0;
    i_lm = (lm < 0) ? 1'($urandom) : 1'(lm);
    case (kind)
      0: begin i_op = 2'b00; i_funct[5] = 1'b0; end
      1: begin i_op = 2'b00; i_funct[5] = 1'b1; end
      2: begin i_op = 2'b01; i_funct[0] = 1'b1; end
      3: begin i_op = 2'b01; i_funct[0] = 1'b0; end
      4: i_op = 2'b10;
      5: i_op = 2'b11;
      default: begin i_op = 2'b00; i_mi = 1'b1; end
    endcase
    for (int i = 0; i < fst; i++) push(4'd0, 1'b0, 1'b0);
    push(4'd0, 1'b1, 1'b0);
    push(4'd1, 1'($urandom), 1'b0);
    case (kind)
      0: begin push(4'd6, 1'($urandom), 0); push(4'd8, 1'($urandom), 0); end
      1: begin push(4'd7, 1'($urandom), 0); push(4'd8, 1'($urandom), 0); end
      2, 3: begin
        push(4'd2, 1'($urandom), 1'b0);
        for (int i = 0; i < wst; i++) push((kind == 2) ? 4'd3 : 4'd5, 0, 0);
        push((kind == 2) ? 4'd3 : 4'd5, 1'b1, 1'b0);
        if (kind == 2) push(4'd4, 1'($urandom), 1'b0);
      end
      4: push(4'd9, 1'($urandom), 1'b0);
      5: push(4'd10, 1'($urandom), 1'b0);
      default: begin
        for (int i = 0; i < MC; i++) push(4'd11, 1'($urandom), i == 0);
        push(4'd12, 1'($urandom), 1'b0);
        if (LM_EN && i_lm) push(4'd13, 1'($urandom), 1'b0);
      end
    endcase
  endtask

  // Drives and checks the first n queued cycles; fields are garbage
  // except in the states that sample them.
  task automatic run_q(int n);
    ent_t e;
    for (int k = 0; k < n && k < q.size(); k++) begin
      e = q[k];
      @(negedge clk);
      MemReady = e.mr;
      if (e.st == 4'd1 || e.st == 4'd2 || e.st == 4'd12) begin
        Op = i_op; Funct = i_funct; MulInstr = i_mi; LongMul = i_lm;
      end else begin
        Op = 2'($urandom); Funct = 6'($urandom);
        MulInstr = 1'($urandom); LongMul = 1'($urandom);
      end
      #1;
      chk("state", {12'd0, State}, {12'd0, e.st});
      chk("ctrl", obs, exp_ctrl(e.st, e.mr, e.first));
      chk("regw_excl", {15'd0, RegW & RegWHi}, 16'd0);
    end
  endtask

  logic [3:0] nh_exp[4];

  initial begin
    reset = 1'b1;
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    chk("rst_ctrl_mr0", obs, exp_ctrl(4'd0, 1'b0, 1'b0));
    @(negedge clk);
    MemReady = 1'b1;
    #1;
    chk("rst_ctrl_mr1", obs, exp_ctrl(4'd0, 1'b1, 1'b0));
    chk("rst_state", {12'd0, State}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    #1;
    chk("rst_wins", {12'd0, State}, 16'd0);

    build(0, 0, 0, -1); run_q(q.size());
    build(2, 1, 3, -1); run_q(q.size());
    build(6, 0, 0, 1);  run_q(q.size());
    build(5, 2, 0, -1); run_q(q.size());
    build(3, 0, 2, -1); run_q(q.size());

    // reset in the second MULEX cycle, then a full multiply again
    build(6, 0, 0, -1);
    run_q(3);
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'($urandom);
    #1;
    chk("rst_mid_mul", obs, exp_ctrl(4'd0, MemReady, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    #1;
    chk("after_rst_mul", {12'd0, State}, 16'd0);
    build(6, 0, 0, 1); run_q(q.size());

    for (int n = 0; n < 60; n++) begin
      build(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3)), -1);
      run_q(q.size());
    end

    // no-handshake instance never stalls in FETCH
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    Op = 2'b11;
    MulInstr = 1'b0;
    nh_exp[0] = 4'd0; nh_exp[1] = 4'd1; nh_exp[2] = 4'd10; nh_exp[3] = 4'd0;
    #1;
    chk("nohs_irwrite", {15'd0, h_IRWrite}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk("nohs_state", {12'd0, h_State}, {12'd0, nh_exp[i]});
      chk("nohs_illegal", {15'd0, h_Illegal}, {15'd0, nh_exp[i] == 4'd10});
    end
    chk("hs_stall", {12'd0, State}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
